program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEM_AW, 16, CPU memory address width.
REQ-002 Parameter ROM_AW, 12, program ROM address width.
REQ-003 Parameter RST_HOLD, 8, cycles cpu_reset stays asserted after the last write.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 load_req  in  1  load request level (menu "Load Program"); rising edge starts a load.
REQ-007 prg_sel  in  3  program index: 0 Empty, 1 zeroToseven, 2 KillBits, 3 SIOEcho, 4 StatusLights, 5 Basic4k32, 6-7 reserved.
REQ-008 rom_addr  out  ROM_AW  program ROM read address.
REQ-009 rom_data  in  8  ROM byte, valid exactly one cycle after rom_addr.
REQ-010 mem_addr  out  MEM_AW  CPU RAM write address.
REQ-011 mem_data  out  8  CPU RAM write data.
REQ-012 mem_we  out  1  one-cycle RAM write strobe.
REQ-013 cpu_reset  out  1  active-high hold/reset to the machine while loading.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse on return to IDLE.

Function
REQ-016 States: IDLE, FETCH, WRITE, HOLD.
REQ-017 Edge detect: load_req registered; start = load_req & ~load_req_q.
REQ-018 IDLE + start: latch prg_sel, rom base, length and load address from the package table; index <= 0; go FETCH, or HOLD directly if length = 0.
REQ-019 prg_sel 0, 6 or 7 SHALL have length 0: no writes, HOLD sequence only.
REQ-020 FETCH: rom_addr = rom_base + index; next state WRITE.
REQ-021 WRITE: mem_we = 1, mem_addr = load_addr + index (mod 2^MEM_AW), mem_data = rom_data; if index = length-1 go HOLD, else index++ and go FETCH.
REQ-022 Throughput: one byte per 2 cycles; first mem_we exactly 2 cycles after the start edge is sampled.
REQ-023 HOLD: counter runs RST_HOLD cycles, then IDLE with done = 1 for one cycle.
REQ-024 cpu_reset = 1 in FETCH, WRITE and HOLD; 0 in IDLE.
REQ-025 start while busy SHALL be ignored; prg_sel changes while busy have no effect.
REQ-026 mem_we SHALL never be high outside WRITE; mem_addr/mem_data hold their last values otherwise.
REQ-027 index width = ROM_AW; table lengths SHALL be <= 2^ROM_AW and rom_base + length SHALL NOT exceed 2^ROM_AW.

Reset
REQ-028 reset_n low: state IDLE, index 0, load_req_q 0, hold counter 0; all outputs 0.
REQ-029 Reset mid-load aborts immediately: no further mem_we, no done pulse, cpu_reset drops to 0.
REQ-030 After reset release, a load_req already high SHALL NOT start a load; a fresh rising edge is required.

Structure
REQ-031 Shared package altair_pkg holds the state enum, the program index constants and the program table (rom_base, length, load_addr per index).
REQ-032 No sub-module; the ROM is external so the loader stays ROM-agnostic.

Verification
REQ-033 prg_sel=1, length 8, load_addr 0x0000, load_req 0->1 -> 8 writes to 0x0000..0x0007 matching the ROM bytes, mem_we every other cycle, cpu_reset high throughout, done 8 cycles after the last write.
REQ-034 prg_sel=0 rising edge -> zero mem_we, cpu_reset high for 8 cycles, then a done pulse.
REQ-035 Second load_req edge during a busy load -> ignored; write count equals the first program's length only.
REQ-036 reset_n low after the 3rd write -> no further writes, cpu_reset=0, done never pulses; a new edge restarts from index 0.
REQ-037 load_addr 0xFFFE, length 4 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-038 load_req held high across reset release -> no load until the next 0->1 transition.

Source files
------------

// File: rtl/altair_pkg.sv
// Shared definitions for the Altair program loader: FSM states, program
// indices and the program table (ROM base, length, CPU load address).
package altair_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_HOLD
  } load_state_e;

  localparam logic [2:0] PRG_EMPTY         = 3'd0;
  localparam logic [2:0] PRG_ZERO_TO_SEVEN = 3'd1;
  localparam logic [2:0] PRG_KILLBITS      = 3'd2;
  localparam logic [2:0] PRG_SIO_ECHO      = 3'd3;
  localparam logic [2:0] PRG_STATUS_LIGHTS = 3'd4;
  localparam logic [2:0] PRG_BASIC_4K32    = 3'd5;

  // length is one bit wider than a ROM address so a full 4 KiB image fits
  typedef struct packed {
    logic [11:0] rom_base;
    logic [12:0] length;
    logic [15:0] load_addr;
  } prog_entry_t;

  function automatic prog_entry_t prog_entry(input logic [2:0] sel);
    prog_entry_t e;
    e = '0;
    case (sel)
      PRG_EMPTY:         e = '0;
      PRG_ZERO_TO_SEVEN: e = '{rom_base: 12'h000, length: 13'd8,    load_addr: 16'h0000};
      PRG_KILLBITS:      e = '{rom_base: 12'h008, length: 13'd24,   load_addr: 16'h0000};
      PRG_SIO_ECHO:      e = '{rom_base: 12'h020, length: 13'd16,   load_addr: 16'h0000};
      PRG_STATUS_LIGHTS: e = '{rom_base: 12'h030, length: 13'd4,    load_addr: 16'hFFFE};
      PRG_BASIC_4K32:    e = '{rom_base: 12'h100, length: 13'd3840, load_addr: 16'h0000};
      default:           e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/program_loader.sv
// Copies a program image from an external ROM into CPU RAM, one byte every
// two cycles, holding the CPU in reset during the copy and for RST_HOLD cycles after.
module program_loader
  import altair_pkg::*;
#(
  parameter int MEM_AW   = 16,
  parameter int ROM_AW   = 12,
  parameter int RST_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_req,
  input  logic [2:0]        prg_sel,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done
);

  localparam int HW = $clog2(RST_HOLD + 1);

  load_state_e       state_q, state_d;
  logic              load_req_q, armed_q, start;
  logic              done_q, done_d;
  logic [ROM_AW-1:0] base_q, base_d, idx_q, idx_d, last_q, last_d;
  logic [MEM_AW-1:0] load_q, load_d, waddr_q, wr_addr;
  logic [7:0]        wdata_q;
  logic [HW-1:0]     hold_q, hold_d;
  prog_entry_t       entry;

  assign entry = prog_entry(prg_sel);
  // armed_q blocks a level already high at reset release from counting as an edge
  assign start = load_req & ~load_req_q & armed_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      load_req_q <= 1'b0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      base_q     <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      load_q     <= '0;
      hold_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      load_req_q <= load_req;
      armed_q    <= 1'b1;
      done_q     <= done_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      load_q     <= load_d;
      hold_q     <= hold_d;
      if (state_q == ST_WRITE) begin
        waddr_q <= wr_addr;
        wdata_q <= rom_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    last_d  = last_q;
    load_d  = load_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d = ROM_AW'(entry.rom_base);
          load_d = MEM_AW'(entry.load_addr);
          idx_d  = '0;
          hold_d = '0;
          if (entry.length == '0) begin
            state_d = ST_HOLD;
          end else begin
            last_d  = ROM_AW'(entry.length - 13'd1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_WRITE;
      ST_WRITE: begin
        if (idx_q == last_q) begin
          hold_d  = '0;
          state_d = ST_HOLD;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (hold_q == HW'(RST_HOLD - 1)) begin
          hold_d  = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_addr   = load_q + MEM_AW'(idx_q);
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = mem_we ? wr_addr : waddr_q;
  assign mem_data  = mem_we ? rom_data : wdata_q;
  assign rom_addr  = base_q + idx_q;
  assign busy      = (state_q != ST_IDLE);
  assign cpu_reset = busy;
  assign done      = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven and randomized loads against a
// program-table reference, plus busy-retrigger and mid-load reset sequences.
module tb_program_loader;

  localparam int RST_HOLD = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_req;
  logic [2:0]  prg_sel;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we, cpu_reset, busy, done;

  program_loader #(.MEM_AW(16), .ROM_AW(12), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .load_req(load_req), .prg_sel(prg_sel),
    .rom_addr(rom_addr), .rom_data(rom_data), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .cpu_reset(cpu_reset),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:4095];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    int         c;
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [2:0]  sel;
    int          len;
    logic [15:0] addr;
    int          base;
  } vec_t;

  wr_t  wq[$];
  vec_t vecs[8];
  int   cyc = 0;
  int   doneCnt = 0;
  int   doneCyc = -1;
  int   protoErr = 0;
  int   nChecks = 0;
  int   nFails = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) wq.push_back('{cyc, mem_addr, mem_data});
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      if (cpu_reset !== busy) protoErr++;
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fillRom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [2:0] sel, output int c0);
    @(negedge clk);
    wq.delete();
    doneCnt  = 0;
    doneCyc  = -1;
    prg_sel  = sel;
    load_req = 1'b1;
    c0       = cyc;
  endtask

  // Expected writes: byte i of the program goes to load_addr+i (16-bit wrap)
  // at cycle c0+2+2i; done follows RST_HOLD cycles after the last write.
  task automatic checkLoad(input string nm, input int len, input logic [15:0] la,
                           input int base, input int c0);
    int          bad;
    logic [15:0] ea;
    for (int i = 0; i < 2 * len + 40 && doneCnt == 0; i++) begin
      @(negedge clk); #1;
    end
    repeat (4) begin @(negedge clk); #1; end
    checkOutput({nm, " done count"}, doneCnt, 1);
    checkOutput({nm, " done cycle"}, doneCyc, c0 + 2 * len + RST_HOLD + 1);
    checkOutput({nm, " write count"}, wq.size(), len);
    if (len > 0 && wq.size() > 0) begin
      bad = 0;
      for (int i = 0; i < wq.size() && i < len; i++) begin
        ea = la + 16'(i);
        if (wq[i].a !== ea || wq[i].d !== rom[base + i] || wq[i].c != c0 + 2 + 2 * i) begin
          bad = i;
          break;
        end
      end
      ea = la + 16'(bad);
      checkOutput({nm, " write addr"}, wq[bad].a, ea);
      checkOutput({nm, " write data"}, wq[bad].d, rom[base + bad]);
      checkOutput({nm, " write cycle"}, wq[bad].c, c0 + 2 + 2 * bad);
    end
    checkOutput({nm, " busy after"}, busy, 1'b0);
    checkOutput({nm, " cpu_reset after"}, cpu_reset, 1'b0);
    load_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c0;
    int idx;

    vecs[0] = '{3'd1, 8,    16'h0000, 12'h000};
    vecs[1] = '{3'd0, 0,    16'h0000, 0};
    vecs[2] = '{3'd6, 0,    16'h0000, 0};
    vecs[3] = '{3'd7, 0,    16'h0000, 0};
    vecs[4] = '{3'd4, 4,    16'hFFFE, 12'h030};
    vecs[5] = '{3'd2, 24,   16'h0000, 12'h008};
    vecs[6] = '{3'd3, 16,   16'h0000, 12'h020};
    vecs[7] = '{3'd5, 3840, 16'h0000, 12'h100};

    fillRom();
    reset_n  = 1'b0;
    load_req = 1'b0;
    prg_sel  = 3'd0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset rom_addr", rom_addr, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset mem_data", mem_data, 0);
    checkOutput("reset mem_we", mem_we, 0);
    checkOutput("reset cpu_reset", cpu_reset, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].sel, c0);
      checkLoad($sformatf("vec%0d sel%0d", v, vecs[v].sel), vecs[v].len,
                vecs[v].addr, vecs[v].base, c0);
    end

    for (int r = 0; r < 6; r++) begin
      fillRom();
      idx = $urandom_range(0, 6);
      applyStimulus(vecs[idx].sel, c0);
      @(negedge clk);
      prg_sel = 3'($urandom);
      checkLoad($sformatf("rand%0d sel%0d", r, vecs[idx].sel), vecs[idx].len,
                vecs[idx].addr, vecs[idx].base, c0);
    end

    // second rising edge (with a different program selected) while busy
    applyStimulus(3'd2, c0);
    repeat (6) @(negedge clk);
    load_req = 1'b0;
    prg_sel  = 3'd1;
    repeat (2) @(negedge clk);
    load_req = 1'b1;
    checkLoad("retrigger", 24, 16'h0000, 12'h008, c0);

    // reset after the third write, with load_req held high through release
    applyStimulus(3'd1, c0);
    for (int i = 0; i < 40 && wq.size() < 3; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("abort writes before reset", wq.size(), 3);
    reset_n = 1'b0;
    #1;
    checkOutput("abort cpu_reset", cpu_reset, 0);
    checkOutput("abort mem_we", mem_we, 0);
    checkOutput("abort busy", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checkOutput("abort writes after release", wq.size(), 3);
    checkOutput("abort done pulses", doneCnt, 0);
    checkOutput("held level no start", busy, 0);
    load_req = 1'b0;
    @(negedge clk);
    applyStimulus(3'd1, c0);
    checkLoad("restart", 8, 16'h0000, 12'h000, c0);

    checkOutput("cpu_reset tracks busy", protoErr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
